// File: rtl/q_sys_pio_pkg.sv
// Shared PIO poller types and constants.
// FSM state encoding, slave read latency and PIO register map.
package q_sys_pio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    READ    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam int         RD_LATENCY    = 1;
  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/q_sys_interval_timer.sv
// Loadable down-counter with zero flag for the poll interval.
// A load takes priority; counting stops at zero.
module q_sys_interval_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/q_sys_dig_error_poller.sv
// Periodic Avalon-MM poller of a PIO data register.
// Tracks newly risen bits, sticky OR of samples and an error irq.
module q_sys_dig_error_poller
  import q_sys_pio_pkg::*;
#(
  parameter int POLL_INTERVAL = 1000,
  parameter int DATA_W        = 20,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              clear,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] last_sample,
  output logic [DATA_W-1:0] sticky_error,
  output logic [CNT_W-1:0]  error_count,
  output logic              error_irq
);

  localparam int TW = 16;
  localparam logic [TW-1:0] RELOAD = TW'(POLL_INTERVAL - 3);

  state_t state, state_nx;

  logic              en_q;
  logic              zero;
  logic              tmr_load;
  logic              tmr_count;
  logic              unused_rd;
  logic [DATA_W-1:0] sample;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] sticky_base;
  logic [CNT_W-1:0]  cnt_base;
  logic              irq_base;

  assign avm_address = PIO_DATA_ADDR;
  assign sample      = avm_readdata[DATA_W-1:0];
  assign unused_rd   = ^avm_readdata;
  assign rise        = sample & ~last_sample;

  // clear zeroes the base; a coincident capture then builds on zero
  assign sticky_base = clear ? '0 : sticky_error;
  assign cnt_base    = clear ? '0 : error_count;
  assign irq_base    = clear ? 1'b0 : error_irq;

  assign tmr_load  = (state == CAPTURE) && enable;
  assign tmr_count = (state == WAIT);

  q_sys_interval_timer #(
    .W (TW)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .count    (tmr_count),
    .load_val (RELOAD),
    .zero     (zero)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en_q) state_nx = READ;
      READ:    state_nx = CAPTURE;
      CAPTURE: state_nx = enable ? WAIT : IDLE;
      WAIT: begin
        if (!enable)   state_nx = IDLE;
        else if (zero) state_nx = READ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      en_q         <= 1'b0;
      avm_read     <= 1'b0;
      last_sample  <= '0;
      sticky_error <= '0;
      error_count  <= '0;
      error_irq    <= 1'b0;
    end else begin
      state    <= state_nx;
      en_q     <= enable;
      avm_read <= (state_nx == READ);
      if (state == CAPTURE) begin
        last_sample  <= sample;
        sticky_error <= sticky_base | sample;
        error_irq    <= irq_base | (|(sample & ~sticky_base));
        if (|rise && !(&cnt_base))
          error_count <= cnt_base + 1'b1;
        else
          error_count <= cnt_base;
      end else begin
        sticky_error <= sticky_base;
        error_count  <= cnt_base;
        error_irq    <= irq_base;
      end
    end
  end

endmodule

// File: tb/tb_q_sys_dig_error_poller.sv
// Directed bench for q_sys_dig_error_poller.
// Second instance uses a 2-bit counter to reach saturation quickly.
module tb_q_sys_dig_error_poller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        clear;
  logic [31:0] rd;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic [19:0] last_sample;
  logic [19:0] sticky_error;
  logic [15:0] error_count;
  logic        error_irq;

  logic        enable_b;
  logic        clear_b;
  logic [31:0] rd_b;
  logic [1:0]  avm_address_b;
  logic        avm_read_b;
  logic [19:0] last_sample_b;
  logic [19:0] sticky_error_b;
  logic [1:0]  error_count_b;
  logic        error_irq_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  q_sys_dig_error_poller #(
    .POLL_INTERVAL (8),
    .DATA_W        (20),
    .CNT_W         (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .avm_address  (avm_address),
    .avm_read     (avm_read),
    .avm_readdata (rd),
    .last_sample  (last_sample),
    .sticky_error (sticky_error),
    .error_count  (error_count),
    .error_irq    (error_irq)
  );

  q_sys_dig_error_poller #(
    .POLL_INTERVAL (4),
    .DATA_W        (20),
    .CNT_W         (2)
  ) dut_b (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable_b),
    .clear        (clear_b),
    .avm_address  (avm_address_b),
    .avm_read     (avm_read_b),
    .avm_readdata (rd_b),
    .last_sample  (last_sample_b),
    .sticky_error (sticky_error_b),
    .error_count  (error_count_b),
    .error_irq    (error_irq_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for a READ, present v on the bus, return after the capture edge
  task automatic poll(input bit b, input logic [31:0] v, input bit clr);
    int n = 0;
    while (!(b ? avm_read_b : avm_read) && n < 40) begin
      tick();
      n++;
    end
    check("poll_timeout", 32'(n < 40), 32'd1);
    if (b) rd_b = v;
    else   rd = v;
    tick();
    if (clr) clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    reset_n  = 1'b0;
    enable   = 1'b1;
    clear    = 1'b0;
    rd       = 32'h0;
    enable_b = 1'b0;
    clear_b  = 1'b0;
    rd_b     = 32'h0;
    repeat (3) tick();

    check("rst_read",   32'(avm_read),     32'h0);
    check("rst_addr",   32'(avm_address),  32'h0);
    check("rst_last",   32'(last_sample),  32'h0);
    check("rst_sticky", 32'(sticky_error), 32'h0);
    check("rst_count",  32'(error_count),  32'h0);
    check("rst_irq",    32'(error_irq),    32'h0);

    reset_n = 1'b1;
    tick();
    check("rel_c1_read", 32'(avm_read), 32'h0);
    tick();
    check("rel_c2_read", 32'(avm_read), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("gap_read", 32'(avm_read), 32'h0);
      check("gap_addr", 32'(avm_address), 32'h0);
    end
    tick();
    check("period_read", 32'(avm_read), 32'h1);

    poll(1'b0, 32'h0, 1'b0);
    check("p0_count",  32'(error_count),  32'h0);
    check("p0_sticky", 32'(sticky_error), 32'h0);
    check("p0_irq",    32'(error_irq),    32'h0);
    poll(1'b0, 32'h5, 1'b0);
    check("p5_last",   32'(last_sample),  32'h5);
    check("p5_count",  32'(error_count),  32'h1);
    check("p5_sticky", 32'(sticky_error), 32'h5);
    check("p5_irq",    32'(error_irq),    32'h1);
    poll(1'b0, 32'h5, 1'b0);
    check("p5b_count",  32'(error_count),  32'h1);
    check("p5b_sticky", 32'(sticky_error), 32'h5);

    pulse_clear();
    check("clr1_sticky", 32'(sticky_error), 32'h0);
    check("clr1_count",  32'(error_count),  32'h0);
    check("clr1_irq",    32'(error_irq),    32'h0);
    check("clr1_last",   32'(last_sample),  32'h5);

    poll(1'b0, 32'h0, 1'b0);
    check("q0_irq",   32'(error_irq),   32'h0);
    check("q0_count", 32'(error_count), 32'h0);
    poll(1'b0, 32'h1, 1'b0);
    check("q1_count",  32'(error_count),  32'h1);
    check("q1_sticky", 32'(sticky_error), 32'h1);
    poll(1'b0, 32'h2, 1'b0);
    check("q2_count",  32'(error_count),  32'h2);
    check("q2_sticky", 32'(sticky_error), 32'h3);
    check("q2_irq",    32'(error_irq),    32'h1);

    pulse_clear();
    check("clr2_sticky", 32'(sticky_error), 32'h0);
    check("clr2_count",  32'(error_count),  32'h0);
    check("clr2_irq",    32'(error_irq),    32'h0);
    check("clr2_last",   32'(last_sample),  32'h2);

    poll(1'b0, 32'h1, 1'b0);
    check("r1_count",  32'(error_count),  32'h1);
    check("r1_sticky", 32'(sticky_error), 32'h1);
    poll(1'b0, 32'hFFF8_0000, 1'b1);
    check("cc_last",   32'(last_sample),  32'h80000);
    check("cc_sticky", 32'(sticky_error), 32'h80000);
    check("cc_count",  32'(error_count),  32'h1);
    check("cc_irq",    32'(error_irq),    32'h1);

    enable_b = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      poll(1'b1, 32'h0, 1'b0);
      poll(1'b1, 32'h1, 1'b0);
      check("sat_count", 32'(error_count_b), (k < 3) ? 32'(k) : 32'h3);
    end

    n = 0;
    while (!avm_read && n < 40) begin
      tick();
      n++;
    end
    check("drop_timeout", 32'(n < 40), 32'd1);
    rd = 32'h7;
    enable = 1'b0;
    tick();
    tick();
    check("drop_last",   32'(last_sample),  32'h7);
    check("drop_count",  32'(error_count),  32'h2);
    check("drop_sticky", 32'(sticky_error), 32'h80007);
    check("drop_irq",    32'(error_irq),    32'h1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (avm_read) seen++;
    end
    check("drop_no_read", 32'(seen), 32'h0);

    enable = 1'b1;
    n = 0;
    while (!avm_read && n < 40) begin
      tick();
      n++;
    end
    check("rr_timeout", 32'(n < 40), 32'd1);
    reset_n = 1'b0;
    tick();
    check("rr_read",   32'(avm_read),     32'h0);
    check("rr_last",   32'(last_sample),  32'h0);
    check("rr_sticky", 32'(sticky_error), 32'h0);
    check("rr_count",  32'(error_count),  32'h0);
    check("rr_irq",    32'(error_irq),    32'h0);
    tick();
    check("rr_hold_read", 32'(avm_read), 32'h0);
    reset_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
